// File: rtl/sevenseg_scan_ctrl_if.sv
// Bus bundle for the four-digit seven-segment scan controller: the load/hold
// controls and value inputs from the host, plus the display drive back out.
interface sevenseg_scan_ctrl_if;
  logic        load;
  logic [15:0] value_in;
  logic [3:0]  dp_in;
  logic        hold;
  logic [3:0]  nibble;
  logic [3:0]  an;
  logic        dp_n;
  logic [1:0]  digit_idx;

  modport master (
    output load, value_in, dp_in, hold,
    input  nibble, an, dp_n, digit_idx
  );

  modport slave (
    input  load, value_in, dp_in, hold,
    output nibble, an, dp_n, digit_idx
  );
endinterface

// File: rtl/sevenseg_scan_ctrl.sv
// Four-digit time-multiplexed common-anode scan controller with per-slot blanking.
// Optional macro SEVENSEG_LEADING_ZERO_BLANK_EN suppresses leading-zero digits.
module sevenseg_scan_ctrl #(
  parameter int SCAN_DIV  = 100000,
  parameter int BLANK_CYC = 2
) (
  input logic              clk,
  input logic              rst,
  sevenseg_scan_ctrl_if.slave bus
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);

  typedef enum logic {BLANK, SHOW} state_t;
  localparam state_t SLOT_START = (BLANK_CYC == 0) ? SHOW : BLANK;

  logic [15:0]      shadow_val, val_nx;
  logic [3:0]       shadow_dp, dp_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [1:0]       idx, idx_nx;
  state_t           state, state_nx;
  logic [3:0]       nibble_r, nibble_d;
  logic [3:0]       an_r, an_d;
  logic             dp_n_r, dp_n_d;

`ifdef SEVENSEG_LEADING_ZERO_BLANK_EN
  // A digit is a leading zero when it and every more-significant nibble are zero.
  function automatic logic lead_zero(input logic [15:0] val, input logic [3:0] dp,
                                     input logic [1:0] sel);
    return (sel != 2'd0) && !dp[sel] && ((val >> {sel, 2'b00}) == 16'h0000);
  endfunction
`endif

  always_comb begin
    val_nx   = bus.load ? bus.value_in : shadow_val;
    dp_nx    = bus.load ? bus.dp_in    : shadow_dp;
    cnt_nx   = cnt;
    idx_nx   = idx;
    state_nx = state;
    if (!bus.hold) begin
      if (cnt == CNT_LAST) begin
        cnt_nx   = '0;
        idx_nx   = idx + 2'd1;
        state_nx = SLOT_START;
      end else begin
        cnt_nx = cnt + CNT_W'(1);
        if (BLANK_CYC > 0 && state == BLANK && cnt == BLANK_LAST)
          state_nx = SHOW;
      end
    end
  end

  // Outputs are decoded from the post-edge state so they register with no lag.
  always_comb begin
    nibble_d = val_nx[{idx_nx, 2'b00} +: 4];
    an_d     = 4'b1111;
    dp_n_d   = 1'b1;
    if (state_nx == SHOW) begin
      an_d   = ~(4'b0001 << idx_nx);
      dp_n_d = ~dp_nx[idx_nx];
`ifdef SEVENSEG_LEADING_ZERO_BLANK_EN
      if (lead_zero(val_nx, dp_nx, idx_nx)) begin
        an_d   = 4'b1111;
        dp_n_d = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_val <= '0;
      shadow_dp  <= '0;
      cnt        <= '0;
      idx        <= '0;
      state      <= SLOT_START;
      nibble_r   <= '0;
      an_r       <= 4'b1111;
      dp_n_r     <= 1'b1;
    end else begin
      shadow_val <= val_nx;
      shadow_dp  <= dp_nx;
      cnt        <= cnt_nx;
      idx        <= idx_nx;
      state      <= state_nx;
      nibble_r   <= nibble_d;
      an_r       <= an_d;
      dp_n_r     <= dp_n_d;
    end
  end

  assign bus.nibble    = nibble_r;
  assign bus.an        = an_r;
  assign bus.dp_n      = dp_n_r;
  assign bus.digit_idx = idx;

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Bench for sevenseg_scan_ctrl: directed scenarios plus random traffic, checked
// against a position-in-frame reference model.
module tb_sevenseg_scan_ctrl;

  localparam int SD = 8;
  localparam int BC = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  sevenseg_scan_ctrl_if bus ();

  sevenseg_scan_ctrl #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: frame position t counts unheld cycles since reset.
  int          t = 0;
  logic [15:0] sv = '0;
  logic [3:0]  sdp = '0;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s t=%0d got=%h exp=%h", tag, t, got, exp);
    end
  endtask

  task automatic check_model();
    int slot, ph;
    logic [3:0] e_an, e_nib;
    logic e_dpn;
    slot  = (t / SD) % 4;
    ph    = t % SD;
    e_nib = 4'((sv >> (4 * slot)) & 16'hF);
    e_an  = 4'b1111;
    e_dpn = 1'b1;
    if (ph >= BC) begin
      e_an  = ~(4'b0001 << slot);
      e_dpn = ~sdp[slot];
`ifdef SEVENSEG_LEADING_ZERO_BLANK_EN
      if (slot != 0 && !sdp[slot] && (sv >> (4 * slot)) == 16'h0) begin
        e_an  = 4'b1111;
        e_dpn = 1'b1;
      end
`endif
    end
    chk("an", {12'h0, bus.an}, {12'h0, e_an});
    chk("nibble", {12'h0, bus.nibble}, {12'h0, e_nib});
    chk("dp_n", {15'h0, bus.dp_n}, {15'h0, e_dpn});
    chk("digit_idx", {14'h0, bus.digit_idx}, 16'(slot));
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) begin
      t = 0; sv = '0; sdp = '0;
    end else begin
      if (bus.load) begin sv = bus.value_in; sdp = bus.dp_in; end
      if (!bus.hold) t++;
    end
    #1;
    check_model();
  endtask

  task automatic seek(input int target);
    for (int k = 0; k < 4 * SD + 2 && (t % (4 * SD)) != target; k++) step();
    chk("seek", 16'(t % (4 * SD)), 16'(target));
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    bus.load = 1'b1; bus.value_in = v; bus.dp_in = d;
    step();
    bus.load = 1'b0;
  endtask

  initial begin
    bus.load = 1'b0; bus.value_in = '0; bus.dp_in = '0; bus.hold = 1'b0;
    step(); step();
    chk("rst_an", {12'h0, bus.an}, 16'h000F);
    rst = 1'b0;
    repeat (40) step();

    do_load(16'h1A3F, 4'b0100);
    repeat (4 * SD) step();

    seek(SD + 4);
    bus.hold = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin
        do_load(16'h00B0, 4'b0000);
        chk("hold_nib", {12'h0, bus.nibble}, 16'h000B);
        chk("hold_an", {12'h0, bus.an}, 16'h000D);
      end else step();
    end
    bus.hold = 1'b0;
    repeat (3) step();
    chk("hold_tail_idx", {14'h0, bus.digit_idx}, 16'd1);
    step();
    chk("hold_next_idx", {14'h0, bus.digit_idx}, 16'd2);

    seek(4 * SD - 1);
    do_load(16'h0005, 4'b0000);
    repeat (BC) step();
    chk("wrap_nib", {12'h0, bus.nibble}, 16'h0005);
    chk("wrap_an", {12'h0, bus.an}, 16'h000E);

    seek(2 * SD + 4);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_an", {12'h0, bus.an}, 16'h000F);
    repeat (10) step();

    do_load(16'h0070, 4'b1000);
    repeat (4 * SD) step();

    for (int n = 0; n < 800; n++) begin
      logic [15:0] v;
      v = '0;
      for (int j = 0; j < 4; j++)
        if ($urandom_range(0, 1) == 1) v[4*j +: 4] = 4'($urandom);
      bus.value_in = v;
      bus.dp_in    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      bus.load     = ($urandom_range(0, 7) == 0);
      bus.hold     = ($urandom_range(0, 5) == 0);
      rst          = ($urandom_range(0, 99) == 0);
      step();
    end
    bus.load = 1'b0; bus.hold = 1'b0; rst = 1'b0;
    repeat (4) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
